// File: rtl/vec_add_arbiter_if.sv
// Handshake bundle for vec_add_arbiter. It carries the NUM_REQ operand request
// channels toward the arbiter and the single result channel toward the consumer.
// The master modport is the requester/consumer side; the slave modport is the arbiter.
interface vec_add_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int VEC_LEN    = 8,
    parameter int DATA_WIDTH = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                              req_vld;
    logic [NUM_REQ-1:0]                              req_rdy;
    logic [NUM_REQ-1:0][VEC_LEN-1:0][DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][VEC_LEN-1:0][DATA_WIDTH-1:0] req_b;
    logic                                            out_vld;
    logic                                            out_rdy;
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0]              out_sum;
    logic [ID_W-1:0]                                 out_id;

    modport master (
        output req_vld, req_a, req_b, out_rdy,
        input  req_rdy, out_vld, out_sum, out_id
    );

    modport slave (
        input  req_vld, req_a, req_b, out_rdy,
        output req_rdy, out_vld, out_sum, out_id
    );
endinterface

// File: rtl/vec_add_arbiter.sv
// vec_add_arbiter: several requesters share one element-wise vector adder.
// A round-robin grant picks one valid requester per cycle. Its sum goes into a
// one-deep output register, together with the requester's index.
// Optional feature macro: VEC_ADD_ARB_BURST_EN. When it is defined, the arbiter
// keeps granting the same requester for up to BURST_LEN back-to-back accepts.

// Element-wise adder. Each lane wraps modulo 2^DATA_WIDTH.
module vec_add #(
    parameter int VEC_LEN    = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                               vld_in,
    input  logic                               rdy_in,
    input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] a,
    input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] b,
    output logic [VEC_LEN-1:0][DATA_WIDTH-1:0] sum,
    output logic                               vld_out
);
    // The carry out of the top bit is dropped, so the result is the same for signed and unsigned lanes.
    function automatic logic [DATA_WIDTH-1:0] wrap_add(input logic [DATA_WIDTH-1:0] x,
                                                       input logic [DATA_WIDTH-1:0] y);
        return x + y;
    endfunction

    // Lane-by-lane addition.
    always_comb begin
        for (int l = 0; l < VEC_LEN; l++) begin
            sum[l] = wrap_add(a[l], b[l]);
        end
    end

    assign vld_out = vld_in & rdy_in;
endmodule

module vec_add_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int VEC_LEN    = 8,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    vec_add_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Requester index arithmetic wraps modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [ID_W-1:0] wrap_idx(input int v);
        return ID_W'(v % NUM_REQ);
    endfunction

    logic [ID_W-1:0]                    rr_ptr;
    logic                               gnt_found;
    logic [ID_W-1:0]                    gnt_id;
    logic                               can_acc;
    logic                               accept;
    logic [NUM_REQ-1:0]                 rdy;
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0] sel_a;
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0] sel_b;
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0] add_sum;
    logic                               add_vld;
    logic                               vld_p1;
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0] sum_p1;
    logic [ID_W-1:0]                    id_p1;

    // The result register can take new data when it is empty or is being drained this cycle.
    assign can_acc = !vld_p1 || bus.out_rdy;

    // First valid requester, searching upward from rr_ptr with wrap-around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && bus.req_vld[wrap_idx(int'(rr_ptr) + k)]) begin
                gnt_found = 1'b1;
                gnt_id    = wrap_idx(int'(rr_ptr) + k);
            end
        end
    end

    // One-hot ready to the winner; all zero while in reset or while the output is stalled.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rdy[i] = !rst && can_acc && gnt_found && (gnt_id == ID_W'(i));
        end
    end

    assign bus.req_rdy = rdy;

    // Only the winner's operands are routed to the shared adder.
    assign sel_a = bus.req_a[gnt_id];
    assign sel_b = bus.req_b[gnt_id];

    vec_add #(
        .VEC_LEN    (VEC_LEN),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_vec_add (
        .vld_in  (1'b1),
        .rdy_in  (1'b1),
        .a       (sel_a),
        .b       (sel_b),
        .sum     (add_sum),
        .vld_out (add_vld)
    );

    // The reset term is not repeated here: the flops that accept drives are held clear while rst is high.
    assign accept = can_acc && gnt_found && add_vld;

    // Output stage: load on accept, empty on a drain with no accept, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            sum_p1 <= '0;
            id_p1  <= '0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            sum_p1 <= add_sum;
            id_p1  <= gnt_id;
        end else if (bus.out_rdy) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.out_vld = vld_p1;
    assign bus.out_sum = sum_p1;
    assign bus.out_id  = id_p1;

`ifdef VEC_ADD_ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    logic             locked;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_next;

    // A repeat accept of the locked owner extends the run. Any other accept starts a new run at one.
    assign cnt_next = (locked && gnt_id == rr_ptr) ? burst_cnt + CNT_W'(1) : CNT_W'(1);

    // Burst lock: rr_ptr stays on the owner until BURST_LEN accepts, or until a free cycle finds it idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            locked    <= 1'b0;
            burst_cnt <= '0;
        end else if (accept) begin
            if (cnt_next == CNT_W'(BURST_LEN)) begin
                locked    <= 1'b0;
                burst_cnt <= '0;
                rr_ptr    <= wrap_idx(int'(gnt_id) + 1);
            end else begin
                locked    <= 1'b1;
                burst_cnt <= cnt_next;
                rr_ptr    <= gnt_id;
            end
        end else if (can_acc && locked) begin
            locked    <= 1'b0;
            burst_cnt <= '0;
            rr_ptr    <= wrap_idx(int'(rr_ptr) + 1);
        end
    end
`else
    logic unused_burst_len;
    assign unused_burst_len = (BURST_LEN > 0);

    // Plain round-robin: after each accept the pointer moves past the requester just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= wrap_idx(int'(gnt_id) + 1);
        end
    end
`endif
endmodule

// File: tb/tb_vec_add_arbiter.sv
// Testbench for vec_add_arbiter: fixed vectors plus random traffic. A transaction-level model follows the
// arbitration and result-register rules. Burst expectations are selected by VEC_ADD_ARB_BURST_EN.
module tb_vec_add_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int VEC_LEN    = 8;
    localparam int DATA_WIDTH = 16;
    localparam int BURST_LEN  = 4;
    localparam int SUM_W      = VEC_LEN * DATA_WIDTH;

    typedef logic [VEC_LEN-1:0][DATA_WIDTH-1:0] vec_t;

    typedef struct {
        logic [NUM_REQ-1:0]    vld;
        logic                  ordy;
        logic [NUM_REQ-1:0]    exp_rdy;
        int                    exp_id;
        logic [DATA_WIDTH-1:0] exp_lane;
    } row_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vec_add_arbiter_if #(.NUM_REQ(NUM_REQ), .VEC_LEN(VEC_LEN), .DATA_WIDTH(DATA_WIDTH)) bus ();

    vec_add_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .VEC_LEN    (VEC_LEN),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state, kept at transaction level.
    bit   m_vld;
    vec_t m_sum;
    int   m_id;
    int   m_ptr;
    int   m_owner;
    int   m_run;

    task automatic check(input string name, input logic [SUM_W-1:0] act, input logic [SUM_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_vld   = 1'b0;
        m_sum   = '0;
        m_id    = 0;
        m_ptr   = 0;
        m_owner = -1;
        m_run   = 0;
    endtask

    function automatic int model_grant();
        int start;
        start = m_ptr;
`ifdef VEC_ADD_ARB_BURST_EN
        if (m_owner >= 0) start = m_owner;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (bus.req_vld[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic set_ops(input int r, input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        for (int l = 0; l < VEC_LEN; l++) begin
            bus.req_a[r][l] = a;
            bus.req_b[r][l] = b;
        end
    endtask

    // One clock with the inputs as currently driven: check ready, advance the model, check the outputs.
    task automatic step(output int acc);
        int                 g;
        bit                 can;
        logic [NUM_REQ-1:0] exp_rdy;
        vec_t               nsum;
        #1;
        can     = !m_vld || bus.out_rdy;
        g       = model_grant();
        exp_rdy = '0;
        nsum    = m_sum;
        acc     = (can && g >= 0) ? g : -1;
        if (acc >= 0) begin
            exp_rdy[acc] = 1'b1;
            for (int l = 0; l < VEC_LEN; l++) nsum[l] = bus.req_a[acc][l] + bus.req_b[acc][l];
        end
        check("req_rdy", bus.req_rdy, exp_rdy);
        @(posedge clk);
        #1;
        if (acc >= 0) begin
            m_sum = nsum;
            m_id  = acc;
            m_vld = 1'b1;
`ifdef VEC_ADD_ARB_BURST_EN
            if (m_owner == acc) m_run++;
            else begin
                m_owner = acc;
                m_run   = 1;
            end
            if (m_run == BURST_LEN) begin
                m_owner = -1;
                m_run   = 0;
                m_ptr   = (acc + 1) % NUM_REQ;
            end
`else
            m_ptr = (acc + 1) % NUM_REQ;
`endif
        end else if (can) begin
            m_vld = 1'b0;
`ifdef VEC_ADD_ARB_BURST_EN
            if (m_owner >= 0) begin
                m_ptr   = (m_owner + 1) % NUM_REQ;
                m_owner = -1;
                m_run   = 0;
            end
`endif
        end
        check("out_vld", bus.out_vld, m_vld);
        check("out_id", bus.out_id, m_id);
        check("out_sum", bus.out_sum, m_sum);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    row_t tbl[5];
    int   id_seq[9];
    int   acc;
    int   hold_id;
    vec_t hold_sum;
    vec_t exp_w;
    bit   pend[NUM_REQ];

    initial begin
`ifdef VEC_ADD_ARB_BURST_EN
        tbl[0] = '{4'b1111, 1'b1, 4'b0001, 0, 16'd11};
        tbl[1] = '{4'b1111, 1'b1, 4'b0001, 0, 16'd11};
        tbl[2] = '{4'b1111, 1'b1, 4'b0001, 0, 16'd11};
        tbl[3] = '{4'b1111, 1'b1, 4'b0001, 0, 16'd11};
        tbl[4] = '{4'b1111, 1'b1, 4'b0010, 1, 16'd12};
        id_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
        tbl[0] = '{4'b1111, 1'b1, 4'b0001, 0, 16'd11};
        tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1, 16'd12};
        tbl[2] = '{4'b1111, 1'b1, 4'b0100, 2, 16'd13};
        tbl[3] = '{4'b1111, 1'b1, 4'b1000, 3, 16'd14};
        tbl[4] = '{4'b1111, 1'b1, 4'b0001, 0, 16'd11};
        id_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif

        // Reset held with every requester valid.
        rst         = 1'b1;
        bus.req_vld = '1;
        bus.req_a   = '0;
        bus.req_b   = '0;
        bus.out_rdy = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_vld", bus.out_vld, 1'b0);
        check("rst_req_rdy", bus.req_rdy, 4'b0000);
        check("rst_out_sum", bus.out_sum, '0);
        check("rst_out_id", bus.out_id, 2'd0);
        rst = 1'b0;
        #1;
        check("first_grant", bus.req_rdy, 4'b0001);

        // Round-robin sweep with per-requester operands a=i+1, b=10.
        for (int i = 0; i < NUM_REQ; i++) set_ops(i, DATA_WIDTH'(i + 1), 16'd10);
        for (int r = 0; r < 5; r++) begin
            bus.req_vld = tbl[r].vld;
            bus.out_rdy = tbl[r].ordy;
            #1;
            check("tbl_rdy", bus.req_rdy, tbl[r].exp_rdy);
            step(acc);
            for (int l = 0; l < VEC_LEN; l++) exp_w[l] = tbl[r].exp_lane;
            check("tbl_out_vld", bus.out_vld, 1'b1);
            check("tbl_out_id", bus.out_id, tbl[r].exp_id);
            check("tbl_out_sum", bus.out_sum, exp_w);
        end

        // Backpressure: a result is pending and out_rdy is low for three cycles.
        step(acc);
        hold_id     = m_id;
        hold_sum    = m_sum;
        bus.out_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(acc);
            check("bp_req_rdy", bus.req_rdy, 4'b0000);
            check("bp_out_id", bus.out_id, hold_id);
            check("bp_out_sum", bus.out_sum, hold_sum);
            check("bp_out_vld", bus.out_vld, 1'b1);
        end
        bus.out_rdy = 1'b1;
        #1;
        check("bp_release_rdy", |bus.req_rdy, 1'b1);
        step(acc);
        check("bp_release_vld", bus.out_vld, 1'b1);
`ifndef VEC_ADD_ARB_BURST_EN
        check("bp_next_id", bus.out_id, (hold_id + 1) % NUM_REQ);
`endif

        // Wrap-around: FFFF + 0002 gives 0001 in every lane.
        bus.req_vld = 4'b0001;
        set_ops(0, 16'hFFFF, 16'h0002);
        step(acc);
        for (int l = 0; l < VEC_LEN; l++) exp_w[l] = 16'h0001;
        check("wrap_sum", bus.out_sum, exp_w);
        check("wrap_id", bus.out_id, 2'd0);

        // Asynchronous reset while a result is held.
        bus.req_vld = 4'b0110;
        bus.out_rdy = 1'b0;
        step(acc);
        check("pre_rst_vld", bus.out_vld, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_vld", bus.out_vld, 1'b0);
        check("async_rst_sum", bus.out_sum, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        bus.req_vld = 4'b1111;
        bus.out_rdy = 1'b1;
        #1;
        check("post_rst_grant", bus.req_rdy, 4'b0001);
        step(acc);

        // Two requesters active: the burst lock pattern, or plain alternation without it.
        do_reset();
        set_ops(0, 16'd1, 16'd10);
        set_ops(1, 16'd2, 16'd10);
        bus.req_vld = 4'b0011;
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 9; c++) begin
            step(acc);
            check("pair_id", bus.out_id, id_seq[c]);
        end

        // Requester 0 drops valid after two accepts; requester 1 is next.
        do_reset();
        bus.req_vld = 4'b0011;
        step(acc);
        step(acc);
        bus.req_vld = 4'b0010;
        step(acc);
        check("drop_id", bus.out_id, 2'd1);

        // Random traffic. Requesters hold valid and operands until they are accepted.
        bus.req_vld = '0;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pend[i]        = 1'b1;
                        bus.req_vld[i] = 1'b1;
                        for (int l = 0; l < VEC_LEN; l++) begin
                            bus.req_a[i][l] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : DATA_WIDTH'($urandom);
                            bus.req_b[i][l] = DATA_WIDTH'($urandom);
                        end
                    end else begin
                        bus.req_vld[i] = 1'b0;
                    end
                end
            end
            bus.out_rdy = ($urandom_range(0, 3) != 0);
            step(acc);
            if (acc >= 0) pend[acc] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
